// File: rtl/regfile_sb.sv
// Parametrised register file: NUM_RD combinational read ports, one byte-enabled write port,
// and a per-register busy scoreboard with a registered population count.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rReg,
  output logic [NUM_RD*DATA_W-1:0] rData,
  output logic [NUM_RD-1:0]        rBusy,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        wReg,
  input  logic [DATA_W-1:0]        wData,
  input  logic [DATA_W/8-1:0]      wByteEn,
  input  logic                     markValid,
  input  logic [ADDR_W-1:0]        markReg,
  output logic [ADDR_W:0]          busyCount
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [ADDR_W:0]   busy_count_r;

  logic              wr_ok_s;
  logic              mk_ok_s;
  logic              same_s;
  logic              inc_s;
  logic              dec_s;
  logic [DATA_W-1:0] merged_s;
  logic [DEPTH-1:0]  busy_nxt_s;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [NB-1:0]     en);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
      else       r[i*8 +: 8] = old_v[i*8 +: 8];
    end
    return r;
  endfunction

  assign wr_ok_s  = RegWrite && writable(wReg);
  assign mk_ok_s  = markValid && writable(markReg);
  assign same_s   = (markReg == wReg);
  assign merged_s = merge_bytes(regs_r[wReg], wData, wByteEn);

  // Next busy vector and count delta; a mark landing on the register being written wins.
  always_comb begin
    busy_nxt_s          = busy_r;
    busy_nxt_s[wReg]    = wr_ok_s ? 1'b0 : busy_r[wReg];
    busy_nxt_s[markReg] = mk_ok_s ? 1'b1 : busy_nxt_s[markReg];
    inc_s               = mk_ok_s && !busy_r[markReg];
    dec_s               = wr_ok_s && busy_r[wReg] && !(mk_ok_s && same_s);
  end

  // Register array, busy bits and busy count; reset overrides write and mark.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_r[i] <= '0;
      busy_r       <= '0;
      busy_count_r <= '0;
    end else begin
      if (wr_ok_s) regs_r[wReg] <= merged_s;
      busy_r       <= busy_nxt_s;
      busy_count_r <= busy_count_r + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
    end
  end

  assign busyCount = busy_count_r;

  for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = rReg[gk*ADDR_W +: ADDR_W];

    // Read mux: hard-wired zero register, then same-cycle bypass, then stored state.
    always_comb begin
      if (!writable(addr_s)) begin
        data_s = '0;
        busy_s = 1'b0;
      end else if ((BYPASS != 0) && wr_ok_s && (addr_s == wReg)) begin
        data_s = merged_s;
        busy_s = mk_ok_s && same_s;
      end else begin
        data_s = regs_r[addr_s];
        busy_s = busy_r[addr_s];
      end
    end

    assign rData[gk*DATA_W +: DATA_W] = data_s;
    assign rBusy[gk]                  = busy_s;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with N combinational read ports, one byte-enabled synchronous write port, synchronous clear, and a per-register busy scoreboard. It replaces the fixed 2-read/1-write 32x32 register file in the multicycle datapath. The controller marks a register busy when it issues a multi-cycle producer such as a load or a mult/div, and the write-back clears the mark. Decode reads the busy flags to stall.

## Interface
- DATA_W, 32, register width; must be a multiple of 8
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1, a read of the register being written in the same cycle returns the merged write data

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; one clock; clears all registers and busy bits
- rReg  in  NUM_RD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W]
- rData  out  NUM_RD*DATA_W  read data, packed the same way as rReg
- rBusy  out  NUM_RD  busy flag of each addressed register
- RegWrite  in  1  write strobe
- wReg  in  ADDR_W  write address
- wData  in  DATA_W  write data
- wByteEn  in  DATA_W/8  per-byte write enable; only bytes with a 1 are written
- markValid  in  1  set the busy bit of markReg
- markReg  in  ADDR_W  register to mark busy
- busyCount  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage is 2**ADDR_W x DATA_W. Reset writes 0 to every register and clears every busy bit.
- Write: on a posedge with RegWrite=1, reset=0 and a writable wReg, byte i of reg[wReg] takes wData byte i where wByteEn[i]=1. Other bytes hold.
- The same edge clears busy[wReg] if RegWrite=1, even when wByteEn is all 0.
- Mark: on a posedge with markValid=1, busy[markReg] is set.
- Mark and write to the same register on the same edge: busy ends at 1, because the new producer wins. The data write still happens.
- With ZERO_REG=1: writes to address 0 are dropped, marks of address 0 are dropped, and busy[0] stays 0.
- Read port k is combinational:
  - rData[k] = reg[rReg[k]].
  - rBusy[k] = busy[rReg[k]].
- Bypass with BYPASS=1: if RegWrite=1 and rReg[k]==wReg (and the address is writable), then in the same cycle:
  - rData[k] = the current value with the enabled bytes replaced by wData;
  - rBusy[k] = 1 only if markValid=1 and markReg==wReg, else 0.
- With BYPASS=0, reads show the pre-edge state only.
- busyCount always equals popcount(busy). It is registered and updates on the same edge as busy:
  - +1 when a mark sets a previously clear bit;
  - -1 when a write clears a set bit;
  - 0 change when both land on the same register (result stays busy), or when a mark and a clear hit different registers.
- Re-marking an already busy register does not change busyCount.
- Multiple read ports may address the same register. Each returns an identical value.

## Timing
- Read latency is 0 cycles (combinational from rReg, or from write inputs when bypassing).
- Write and mark latency is 1 cycle: the new value and busy state are visible on the first read after the edge.
- Reset takes priority over RegWrite and markValid on the same edge. After a reset edge: every rData=0, rBusy=0, busyCount=0.
- Reset asserted mid-operation, with registers busy, clears everything in one cycle. Write-backs arriving later for those registers are plain writes; their busy clear is a no-op and busyCount must not underflow.
- Before the first reset, contents are undefined. The datapath asserts reset for at least one cycle at start-up.

## Test plan
- Reset, then write reg 4=50, reg 2=40, reg 3=60 on three edges; read rReg={3,2} -> rData={60,40}, rBusy=0, busyCount=0.
- With ZERO_REG=1, write reg 0=0xDEADBEEF and markValid with markReg=0 -> reg 0 reads 0, rBusy=0, busyCount=0.
- Reg 5=0x11223344, then write wData=0xAABBCCDD with wByteEn=4'b0101 -> reads 0x11BB33DD. Same-cycle bypass read (BYPASS=1) shows 0x11BB33DD before the edge.
- Mark reg 7 -> next cycle rBusy=1 on port reading 7, busyCount=1. Write reg 7 and mark reg 7 on the same edge -> busy stays 1, busyCount=1, data updated. Write reg 7 alone -> busy 0, busyCount=0.
- Mark regs 1, 2, 3 (busyCount=3), assert reset one cycle, then write reg 2 -> busyCount stays 0, all reads 0 except reg 2.
- NUM_RD=4, DATA_W=64: all four ports read distinct and then identical addresses after random writes -> match the scoreboard model every cycle.
